serial_word_collector: RTL and testbench

Downstream stage of the single-bit enable/data stage. Consumes its serial bit output, qualified by an enable, and packs the bits into WIDTH-bit parallel words. Completed words are held in an output register behind a valid/ready handshake, with even parity and a sticky overrun flag. Feeds the word-level logging/check logic in the bench and later parallel consumers.

---
 rtl/serial_word_collector_if.sv | 27 ++
 rtl/serial_word_collector.sv | 77 +++++++
 tb/tb_serial_word_collector.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_collector_if.sv
// Serial-bit in / parallel-word out bundle for serial_word_collector.
// slave: en, d, clear, out_ready in; word_out, out_valid, parity, overrun, bit_count out.
interface serial_word_collector_if #(
  parameter int WIDTH = 8
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             en;
  logic             d;
  logic             clear;
  logic             out_ready;
  logic [WIDTH-1:0] word_out;
  logic             out_valid;
  logic             parity;
  logic             overrun;
  logic [CW-1:0]    bit_count;

  modport master (
    output en, d, clear, out_ready,
    input  word_out, out_valid, parity, overrun, bit_count
  );

  modport slave (
    input  en, d, clear, out_ready,
    output word_out, out_valid, parity, overrun, bit_count
  );
endinterface

// File: rtl/serial_word_collector.sv
// Packs enable-qualified serial bits into WIDTH-bit words behind valid/ready.
// Ports: clk, rst_n (async low), bus (slave): serial in, word/parity/overrun out.
module serial_word_collector #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_word_collector_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_par;
  logic             r_ovr;

  logic [WIDTH-1:0] w_next;
  logic             w_last;
  logic             w_take;

  // w_next is also the completed word when the last bit arrives
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_next = {r_sr[WIDTH-2:0], bus.d};
    end else begin : g_lsb
      assign w_next = {bus.d, r_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_take = !r_valid || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_par   <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (bus.clear) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (r_valid && bus.out_ready)
        r_valid <= 1'b0;
      if (bus.en) begin
        if (w_last) begin
          r_sr  <= '0;
          r_cnt <= '0;
          // a transfer on this edge frees the slot: no bubble
          if (w_take) begin
            r_word  <= w_next;
            r_par   <= ^w_next;
            r_valid <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
        end else begin
          r_sr  <= w_next;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.word_out  = r_word;
  assign bus.out_valid = r_valid;
  assign bus.parity    = r_par;
  assign bus.overrun   = r_ovr;
  assign bus.bit_count = r_cnt;
endmodule

// File: tb/tb_serial_word_collector.sv
// Randomised + directed bench for serial_word_collector (MSB- and LSB-first).
// Both orders run off one stimulus stream against a queue-based model.
module tb_serial_word_collector;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_en = 1'b0;
  logic s_d = 1'b0;
  logic s_clr = 1'b0;
  logic s_rdy = 1'b0;

  always #5 clk = ~clk;

  serial_word_collector_if #(.WIDTH(W)) bm ();
  serial_word_collector_if #(.WIDTH(W)) bl ();

  assign bm.en = s_en;
  assign bm.d = s_d;
  assign bm.clear = s_clr;
  assign bm.out_ready = s_rdy;
  assign bl.en = s_en;
  assign bl.d = s_d;
  assign bl.clear = s_clr;
  assign bl.out_ready = s_rdy;

  serial_word_collector #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .bus(bm)
  );
  serial_word_collector #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bl)
  );

  int n_chk = 0;
  int n_pass = 0;
  string phase = "init";

  logic     q[$];
  logic     m_valid = 1'b0;
  logic     m_ovr = 1'b0;
  logic [W-1:0] m_wm = '0;
  logic [W-1:0] m_wl = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic par_of(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++) if (v[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_wm = '0;
    m_wl = '0;
  endtask

  task automatic model_edge(input logic e, input logic dd,
                            input logic c, input logic r);
    logic vb;
    logic [W-1:0] wm, wl;
    vb = m_valid;
    if (c) begin
      q.delete();
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end else begin
      if (m_valid && r) m_valid = 1'b0;
      if (e) begin
        q.push_back(dd);
        if (q.size() == W) begin
          wm = '0;
          wl = '0;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = q[i];
            wl[i] = q[i];
          end
          q.delete();
          if (!vb || r) begin
            m_wm = wm;
            m_wl = wl;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk({phase, ":valid_m"}, 32'(bm.out_valid), 32'(m_valid));
    chk({phase, ":valid_l"}, 32'(bl.out_valid), 32'(m_valid));
    chk({phase, ":word_m"}, 32'(bm.word_out), 32'(m_wm));
    chk({phase, ":word_l"}, 32'(bl.word_out), 32'(m_wl));
    chk({phase, ":par_m"}, 32'(bm.parity), 32'(par_of(m_wm)));
    chk({phase, ":par_l"}, 32'(bl.parity), 32'(par_of(m_wl)));
    chk({phase, ":ovr_m"}, 32'(bm.overrun), 32'(m_ovr));
    chk({phase, ":ovr_l"}, 32'(bl.overrun), 32'(m_ovr));
    chk({phase, ":cnt_m"}, 32'(bm.bit_count), 32'(q.size()));
    chk({phase, ":cnt_l"}, 32'(bl.bit_count), 32'(q.size()));
  endtask

  task automatic cyc(input logic e, input logic dd,
                     input logic c, input logic r);
    s_en = e;
    s_d = dd;
    s_clr = c;
    s_rdy = r;
    @(posedge clk);
    model_edge(e, dd, c, r);
    #1;
    check_all();
  endtask

  task automatic send(input logic [W-1:0] v, input logic r);
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, v[i], 1'b0, r);
  endtask

  task automatic async_reset();
    s_en = 1'b0;
    s_clr = 1'b0;
    s_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    phase = "reset";
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    phase = "basic";
    send(8'hA5, 1'b1);
    chk("basic:word", 32'(bm.word_out), 32'hA5);
    chk("basic:par", 32'(bm.parity), 32'h0);
    chk("basic:valid", 32'(bm.out_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic:valid_drop", 32'(bm.out_valid), 32'h0);

    phase = "order";
    send(8'hC0, 1'b1);
    chk("order:msb", 32'(bm.word_out), 32'hC0);
    chk("order:lsb", 32'(bl.word_out), 32'h03);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    phase = "sparse";
    for (int i = 0; i < 15; i++) cyc(~i[0], 1'b1, 1'b0, 1'b1);
    chk("sparse:word", 32'(bm.word_out), 32'hFF);
    chk("sparse:par", 32'(bm.parity), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    phase = "overrun";
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    chk("overrun:word", 32'(bm.word_out), 32'h12);
    chk("overrun:flag", 32'(bm.overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("overrun:valid", 32'(bm.out_valid), 32'h0);
    chk("overrun:sticky", 32'(bm.overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("overrun:cleared", 32'(bm.overrun), 32'h0);

    phase = "b2b";
    send(8'h01, 1'b0);
    for (int i = W - 1; i >= 1; i--) cyc(1'b1, i == W - 1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("b2b:word", 32'(bm.word_out), 32'h80);
    chk("b2b:par", 32'(bm.parity), 32'h1);
    chk("b2b:valid", 32'(bm.out_valid), 32'h1);
    chk("b2b:ovr", 32'(bm.overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    phase = "flush";
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush:cnt", 32'(bm.bit_count), 32'h0);
    send(8'h3C, 1'b1);
    chk("flush:word", 32'(bm.word_out), 32'h3C);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    phase = "midreset";
    async_reset();
    chk("midreset:word", 32'(bm.word_out), 32'h0);

    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc(1'($urandom_range(0, 1)), 1'($urandom),
               $urandom_range(0, 63) == 0,
               $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
